// File: rtl/nfsr_keystream_gen.sv
// Nonlinear-feedback keystream generator: seed load, filter-folded warm-up,
// then OUT_W-bit keystream words over a valid/ready handshake.
module nfsr_keystream_gen #(
  parameter int WIDTH       = 80,
  parameter int INIT_ROUNDS = 160,
  parameter int OUT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] seed,
  output logic             busy,
  output logic             init_done,
  output logic [OUT_W-1:0] ks_word,
  output logic             ks_valid,
  input  logic             ks_ready,
  output logic [WIDTH-1:0] state_out
);

  localparam int CW = (INIT_ROUNDS > 1) ? $clog2(INIT_ROUNDS) : 1;
  localparam int PW = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((INIT_ROUNDS > 0) ? INIT_ROUNDS - 1 : 0);
  localparam logic [PW-1:0] POS_LAST = PW'(OUT_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] s_q;
  logic [CW-1:0]    cnt_q;
  logic [PW-1:0]    pos_q;
  logic [OUT_W-1:0] col_q;
  logic [OUT_W-1:0] col_d;
  logic [OUT_W-1:0] word_q;
  logic             valid_q;

  logic f_bit;
  logic z_bit;
  logic at_last;
  logic stall;

  assign f_bit = s_q[0] ^ s_q[5] ^ s_q[6] ^ s_q[9] ^ s_q[17] ^ s_q[22]
               ^ (s_q[4] & s_q[13]) ^ (s_q[8] & s_q[16])
               ^ (s_q[5] & s_q[11] & s_q[14])
               ^ (s_q[2] & s_q[5] & s_q[8] & s_q[10]);
  assign z_bit = s_q[0] ^ s_q[3] ^ (s_q[7] & s_q[12]);

  // Only the step that completes a word can be blocked by an unconsumed word.
  assign at_last = (pos_q == POS_LAST);
  assign stall   = at_last && valid_q && !ks_ready;

  always_comb begin
    col_d        = col_q;
    col_d[pos_q] = z_bit;
  end

  // Handshake: a word transfers on any rising edge where ks_valid and ks_ready
  // are both high; ks_valid stays high and ks_word stable until that happens.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      cnt_q   <= '0;
      pos_q   <= '0;
      col_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else if (stop) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      pos_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            s_q     <= seed;
            cnt_q   <= '0;
            pos_q   <= '0;
            state_q <= (INIT_ROUNDS == 0) ? RUN : INIT;
          end
        end
        INIT: begin
          s_q   <= {f_bit ^ z_bit, s_q[WIDTH-1:1]};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_q <= RUN;
          end
        end
        RUN: begin
          if (!stall) begin
            s_q   <= {f_bit, s_q[WIDTH-1:1]};
            col_q <= col_d;
            if (at_last) begin
              word_q <= col_d;
              pos_q  <= '0;
            end else begin
              pos_q <= pos_q + 1'b1;
            end
          end
          if (!stall && at_last) begin
            valid_q <= 1'b1;
          end else if (valid_q && ks_ready) begin
            valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = (state_q != IDLE);
  assign init_done = (state_q == RUN);
  assign ks_word   = word_q;
  assign ks_valid  = valid_q;
  assign state_out = s_q;

endmodule

// File: tb/tb_nfsr_keystream_gen.sv
// Bench for nfsr_keystream_gen: bit-queue reference model, expected-word
// scoreboard drained by a negedge monitor, plus a 1-bit-word instance.
module tb_nfsr_keystream_gen;
  localparam int W  = 80;
  localparam int IR = 160;
  localparam int OW = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start, stop, ks_ready;
  logic [W-1:0]  seed;
  logic          busy, init_done, ks_valid;
  logic [OW-1:0] ks_word;
  logic [W-1:0]  state_out;

  logic          start1, stop1, ready1;
  logic [W-1:0]  seed1;
  logic          busy1, init_done1, ks_valid1;
  logic [0:0]    ks_word1;
  logic [W-1:0]  state_out1;

  nfsr_keystream_gen #(.WIDTH(W), .INIT_ROUNDS(IR), .OUT_W(OW)) dut (
    .clk(clk), .rst(rst_n), .start(start), .stop(stop), .seed(seed),
    .busy(busy), .init_done(init_done), .ks_word(ks_word),
    .ks_valid(ks_valid), .ks_ready(ks_ready), .state_out(state_out)
  );

  nfsr_keystream_gen #(.WIDTH(W), .INIT_ROUNDS(0), .OUT_W(1)) dut1 (
    .clk(clk), .rst(rst_n), .start(start1), .stop(stop1), .seed(seed1),
    .busy(busy1), .init_done(init_done1), .ks_word(ks_word1),
    .ks_valid(ks_valid1), .ks_ready(ready1), .state_out(state_out1)
  );

  int checks = 0;
  int failures = 0;
  logic [OW-1:0] exp_q[$];
  bit m_s[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // reference model: state is a bit queue, element 0 is s0
  function automatic bit m_f();
    return m_s[0] ^ m_s[5] ^ m_s[6] ^ m_s[9] ^ m_s[17] ^ m_s[22]
         ^ (m_s[4] & m_s[13]) ^ (m_s[8] & m_s[16])
         ^ (m_s[5] & m_s[11] & m_s[14])
         ^ (m_s[2] & m_s[5] & m_s[8] & m_s[10]);
  endfunction

  function automatic bit m_z();
    return m_s[0] ^ m_s[3] ^ (m_s[7] & m_s[12]);
  endfunction

  task automatic m_load(input logic [W-1:0] sd);
    m_s.delete();
    for (int i = 0; i < W; i++) m_s.push_back(sd[i]);
  endtask

  task automatic m_step(input bit fb);
    void'(m_s.pop_front());
    m_s.push_back(fb);
  endtask

  function automatic logic [W-1:0] m_state();
    logic [W-1:0] v;
    for (int i = 0; i < W; i++) v[i] = m_s[i];
    return v;
  endfunction

  task automatic push_words(input logic [W-1:0] sd, input int nw);
    logic [OW-1:0] wd;
    m_load(sd);
    repeat (IR) m_step(m_f() ^ m_z());
    for (int k = 0; k < nw; k++) begin
      for (int b = 0; b < OW; b++) begin
        wd[b] = m_z();
        m_step(m_f());
      end
      exp_q.push_back(wd);
    end
  endtask

  function automatic logic [W-1:0] rand_seed();
    logic [W-1:0] v;
    v[31:0]  = $urandom();
    v[63:32] = $urandom();
    v[79:64] = 16'($urandom_range(0, 65535));
    return v;
  endfunction

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [W-1:0] sd);
    seed = sd;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 3000) begin
      tick(1);
      n++;
    end
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // scoreboard monitor: a word is consumed on the edge after a negedge that saw valid & ready
  always @(negedge clk) begin
    if (rst_n && ks_valid && ks_ready && exp_q.size() > 0) begin
      check("ks_word", ks_word, exp_q.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0]  sd, sd2, s_frozen;
    logic [OW-1:0] w_frozen;
    bit            eb;
    int            n;

    start = 1'b0; stop = 1'b0; seed = '0; ks_ready = 1'b1;
    start1 = 1'b0; stop1 = 1'b0; seed1 = '0; ready1 = 1'b1;
    rst_n = 1'b0;
    tick(3);
    check("rst_valid", ks_valid, 0);
    check("rst_word", ks_word, 0);
    check("rst_busy", busy, 0);
    check("rst_init_done", init_done, 0);
    check("rst_state", state_out, 0);
    @(negedge clk) rst_n = 1'b1;
    tick(1);

    // start and stop together in IDLE: stop wins
    seed = {W{1'b1}}; start = 1'b1; stop = 1'b1;
    tick(1);
    start = 1'b0; stop = 1'b0;
    check("ss_busy", busy, 0);
    check("ss_state", state_out, 0);

    // all-zero seed: latency of first word and all-zero stream
    push_words('0, 4);
    do_start('0);
    check("zero_busy", busy, 1);
    check("zero_in_init", init_done, 0);
    n = 0;
    while (!ks_valid && n < 400) begin
      tick(1);
      n++;
    end
    check("first_valid_cycle", n, IR + OW);
    check("zero_init_done", init_done, 1);
    wait_drain("zero_drain");
    do_stop();
    check("stop_busy", busy, 0);

    // back-pressure stall for 50 cycles
    sd = rand_seed();
    push_words(sd, 6);
    do_start(sd);
    n = 0;
    while (exp_q.size() > 4 && n < 600) begin
      tick(1);
      n++;
    end
    check("stall_reach", exp_q.size(), 4);
    ks_ready = 1'b0;
    tick(20);
    check("stall_valid", ks_valid, 1);
    check("stall_word", ks_word, exp_q[0]);
    s_frozen = state_out;
    w_frozen = ks_word;
    tick(50);
    check("stall_state_frozen", state_out, s_frozen);
    check("stall_word_frozen", ks_word, w_frozen);
    check("stall_valid_held", ks_valid, 1);
    ks_ready = 1'b1;
    wait_drain("stall_drain");
    do_stop();

    // stop after 40 warm-up steps, then restart with a new seed
    sd = rand_seed();
    do_start(sd);
    tick(40);
    do_stop();
    m_load(sd);
    repeat (40) m_step(m_f() ^ m_z());
    check("stop_init_busy", busy, 0);
    check("stop_init_state", state_out, m_state());
    sd2 = rand_seed();
    push_words(sd2, 4);
    do_start(sd2);
    check("restart_seed_load", state_out, sd2);
    wait_drain("restart_drain");
    do_stop();

    // start pulsed while running is ignored
    sd = rand_seed();
    push_words(sd, 5);
    do_start(sd);
    n = 0;
    while (exp_q.size() > 3 && n < 600) begin
      tick(1);
      n++;
    end
    seed = rand_seed();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("run_start_busy", busy, 1);
    wait_drain("run_start_drain");
    do_stop();

    // asynchronous reset with a word pending
    ks_ready = 1'b0;
    sd = rand_seed();
    do_start(sd);
    n = 0;
    while (!ks_valid && n < 400) begin
      tick(1);
      n++;
    end
    check("pre_rst_valid", ks_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", ks_valid, 0);
    check("arst_word", ks_word, 0);
    check("arst_busy", {busy, init_done}, 0);
    check("arst_state", state_out, 0);
    exp_q.delete();
    @(negedge clk) rst_n = 1'b1;
    tick(1);
    ks_ready = 1'b1;
    sd2 = rand_seed();
    push_words(sd2, 4);
    do_start(sd2);
    wait_drain("post_rst_drain");
    do_stop();

    // 1-bit words, no warm-up, all-ones seed: one bit per cycle from cycle 1
    seed1 = {W{1'b1}};
    start1 = 1'b1;
    tick(1);
    start1 = 1'b0;
    m_load({W{1'b1}});
    for (int k = 0; k < 16; k++) begin
      eb = m_z();
      m_step(m_f());
      tick(1);
      check("ow1_bit", {ks_valid1, ks_word1}, {1'b1, eb});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
